// File: rtl/can_bit_tx.sv
// CAN bit-level transmitter: serialises chunks onto the bus with bit stuffing,
// arbitration-loss detection and bit-error abort.
module can_bit_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_tick,
  input  logic       sample_point,
  input  logic       can_rx,
  input  logic [7:0] tx_data,
  input  logic [3:0] tx_nbits,
  input  logic       tx_stuff,
  input  logic       tx_arb,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       can_tx,
  output logic       busy,
  output logic       stuff_bit,
  output logic       done,
  output logic       arb_lost,
  output logic       bit_err
);

  typedef enum logic [1:0] {StIdle, StData, StStuff} state_e;

  state_e     state_q;

  // Holding register (one chunk waiting)
  logic       hold_full_q;
  logic [7:0] hold_data_q;
  logic [3:0] hold_nbits_q;
  logic       hold_stuff_q;
  logic       hold_arb_q;

  // Shift register: remaining bits of the chunk on the bus, MSB next
  logic [7:0] sh_data_q;
  logic [3:0] sh_left_q;
  logic       cur_stuff_q;
  logic       cur_arb_q;

  logic [2:0] run_cnt_q;
  logic       run_val_q;

  logic       can_tx_q;
  logic       done_q;
  logic       arb_lost_q;
  logic       bit_err_q;

  logic [3:0] hold_len;
  logic       use_shift;
  logic       next_bit;
  logic       next_stuff;
  logic [2:0] run_next;
  logic       mismatch;
  logic       stuff_pending;

  always_comb begin
    hold_len      = ((hold_nbits_q == 4'd0) || (hold_nbits_q > 4'd8)) ? 4'd8 : hold_nbits_q;
    use_shift     = (sh_left_q != 4'd0);
    next_bit      = use_shift ? sh_data_q[7] : hold_data_q[7];
    next_stuff    = use_shift ? cur_stuff_q : hold_stuff_q;
    // Run counter only tracks bits of stuffable chunks; a non-stuffed chunk clears it.
    if (!next_stuff) begin
      run_next = 3'd0;
    end else if ((run_cnt_q != 3'd0) && (next_bit == run_val_q)) begin
      run_next = run_cnt_q + 3'd1;
    end else begin
      run_next = 3'd1;
    end
    mismatch      = sample_point && (state_q != StIdle) && (can_rx != can_tx_q);
    stuff_pending = (run_cnt_q == 3'd5);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      hold_full_q  <= 1'b0;
      hold_data_q  <= 8'd0;
      hold_nbits_q <= 4'd0;
      hold_stuff_q <= 1'b0;
      hold_arb_q   <= 1'b0;
      sh_data_q    <= 8'd0;
      sh_left_q    <= 4'd0;
      cur_stuff_q  <= 1'b0;
      cur_arb_q    <= 1'b0;
      run_cnt_q    <= 3'd0;
      run_val_q    <= 1'b0;
      can_tx_q     <= 1'b1;
      done_q       <= 1'b0;
      arb_lost_q   <= 1'b0;
      bit_err_q    <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      arb_lost_q <= 1'b0;
      bit_err_q  <= 1'b0;
      // Readback mismatch aborts the frame and wins over a coincident bit_tick.
      if (mismatch) begin
        if (can_tx_q && !can_rx && (state_q == StData) && cur_arb_q) begin
          arb_lost_q <= 1'b1;
        end else begin
          bit_err_q <= 1'b1;
        end
        can_tx_q    <= 1'b1;
        state_q     <= StIdle;
        hold_full_q <= 1'b0;
        sh_data_q   <= 8'd0;
        sh_left_q   <= 4'd0;
        run_cnt_q   <= 3'd0;
      end else begin
        if (tx_valid && !hold_full_q) begin
          hold_full_q  <= 1'b1;
          hold_data_q  <= tx_data;
          hold_nbits_q <= tx_nbits;
          hold_stuff_q <= tx_stuff;
          hold_arb_q   <= tx_arb;
        end
        if (bit_tick) begin
          if ((state_q != StIdle) && stuff_pending) begin
            state_q   <= StStuff;
            can_tx_q  <= ~run_val_q;
            run_cnt_q <= 3'd1;
            run_val_q <= ~run_val_q;
          end else if (use_shift || hold_full_q) begin
            state_q   <= StData;
            can_tx_q  <= next_bit;
            run_cnt_q <= run_next;
            run_val_q <= next_bit;
            if (use_shift) begin
              sh_data_q <= {sh_data_q[6:0], 1'b0};
              sh_left_q <= sh_left_q - 4'd1;
            end else begin
              sh_data_q   <= {hold_data_q[6:0], 1'b0};
              sh_left_q   <= hold_len - 4'd1;
              cur_stuff_q <= hold_stuff_q;
              cur_arb_q   <= hold_arb_q;
              hold_full_q <= 1'b0;
            end
          end else if (state_q != StIdle) begin
            state_q   <= StIdle;
            can_tx_q  <= 1'b1;
            done_q    <= 1'b1;
            run_cnt_q <= 3'd0;
          end
        end
      end
    end
  end

  assign tx_ready  = ~hold_full_q;
  assign can_tx    = can_tx_q;
  assign busy      = (state_q != StIdle);
  assign stuff_bit = (state_q == StStuff);
  assign done      = done_q;
  assign arb_lost  = arb_lost_q;
  assign bit_err   = bit_err_q;

endmodule
